// File: rtl/uart_stim_pkg.sv
// Shared definitions for the uart_stim_tx serial stimulus transactor:
// FSM state encodings and the default bit period.
package uart_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Two half periods of the bench-side serial monitor (2 x 53 cycles).
  localparam int DEFAULT_CLKS_PER_BIT = 106;

endpackage

// File: rtl/uart_stim_fifo.sv
// Byte FIFO feeding the uart_stim_tx serialiser; power-of-two DEPTH,
// pointers wrap naturally and the level carries one extra bit to tell full from empty.
module uart_stim_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int DEPTH_I = DEPTH;
  localparam logic [AW:0] FULL_LEVEL = DEPTH_I[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage has no reset; the level and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_stim_tx.sv
// UART 8N1 stimulus transmitter driving the SoC ser_rx pin from a byte FIFO.
// Define UART_STIM_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int DIV_LAST_I = CLKS_PER_BIT - 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_LAST_I[DIV_W-1:0];

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       sh;
  logic             bit_end;
  logic             line_nxt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [7:0]       head;
`ifdef UART_STIM_TX_PARITY_EN
  logic             par;
`endif

  // Readiness comes from the registered level only, so a full FIFO refuses
  // a push even in a cycle where the serialiser pops.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign bit_end  = (div == DIV_LAST);

  uart_stim_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    line_nxt  = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        line_nxt = 1'b0;
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        line_nxt = sh[0];
        if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_STIM_TX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_STIM_TX_PARITY_EN
      ST_PARITY: begin
        line_nxt = par;
        if (bit_end) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more bytes wait.
        if (bit_end) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      ser_tx  <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_STIM_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      ser_tx <= line_nxt;
      busy   <= (state != ST_IDLE) || push || !empty;
      if (pop) begin
        sh      <= head;
        bit_cnt <= '0;
        div     <= '0;
`ifdef UART_STIM_TX_PARITY_EN
        par     <= ^head;
`endif
      end else if (state != ST_IDLE) begin
        div <= bit_end ? '0 : div + DIV_W'(1);
        if (state == ST_DATA && bit_end) begin
          sh      <= sh >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule
